// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and word geometry for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int WORD_BITS = 32;
  localparam int ADDR_LSB = 2;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between initiator and responder
interface dmem_responder_if;
  import dmem_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [31:0] req_addr;
  logic [WORD_BITS-1:0] req_wdata;
  logic resp_valid;
  logic resp_ready;
  logic [WORD_BITS-1:0] resp_rdata;
  logic resp_err;
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/word_ram.sv
// word_ram: DEPTH x 32 storage, synchronous write, combinational read, no reset
module word_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_addr,
  input  logic [WORD_BITS-1:0] i_wdata,
  output logic [WORD_BITS-1:0] o_rdata
);
  logic [WORD_BITS-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_write, r_err;
  logic [31:0] r_addr;
  logic [WORD_BITS-1:0] r_wdata, r_rdata, w_wdata, w_rdata;
  logic [31:0] w_addr;
  logic w_accept, w_enter, w_write, w_err, w_we;
  assign w_accept = r_state == IDLE && bus.req_valid;
  // With zero wait states RESP is entered on the acceptance edge, so use the live request
  assign w_write = r_state == IDLE ? bus.req_write : r_write;
  assign w_addr = r_state == IDLE ? bus.req_addr : r_addr;
  assign w_wdata = r_state == IDLE ? bus.req_wdata : r_wdata;
  assign w_err = w_addr[ADDR_LSB-1:0] != '0 || (w_addr >> ADDR_LSB) >= 32'(DEPTH);
  assign w_enter = w_next == RESP && r_state != RESP;
  assign w_we = w_enter && w_write && !w_err && !reset;
  word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .i_we(w_we),
    .i_addr(w_addr[ADDR_LSB +: AW]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = WAIT_CYCLES == 0 ? RESP : BUSY;
    else if (r_state == BUSY && r_cnt == 4'd1) w_next = RESP;
    else if (r_state == RESP && bus.resp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      r_cnt <= w_accept ? 4'(WAIT_CYCLES) : r_state == BUSY ? r_cnt - 4'd1 : r_cnt;
      if (w_enter) begin
        r_err <= w_err;
        r_rdata <= (w_write || w_err) ? '0 : w_rdata;
      end
    end
  assign bus.req_ready = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP;
  assign bus.resp_err = r_state == RESP && r_err;
  assign bus.resp_rdata = r_state == RESP ? r_rdata : '0;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request acceptance and response (range 0..15).
REQ-003 SHALL have port clk input 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid input 1: initiator presents a request.
REQ-006 SHALL have port req_ready output 1: responder can accept a request.
REQ-007 SHALL have port req_write input 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr input 32: byte address.
REQ-009 SHALL have port req_wdata input 32: store data.
REQ-010 SHALL have port resp_valid output 1: response available.
REQ-011 SHALL have port resp_ready input 1: initiator accepts response.
REQ-012 SHALL have port resp_rdata output 32: load data.
REQ-013 SHALL have port resp_err output 1: request was misaligned or out of range.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; handshake is req_valid & req_ready at a rising edge.
REQ-016 On handshake, SHALL register write, addr and wdata, and load the wait counter with WAIT_CYCLES.
REQ-017 On handshake with WAIT_CYCLES=0, SHALL go IDLE->RESP; otherwise IDLE->BUSY.
REQ-018 In BUSY, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-019 resp_valid SHALL assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 Error condition: addr[1:0]!=0, or addr[31:2]>=DEPTH.
REQ-021 A store without error SHALL write RAM[addr[31:2]] on the edge that enters RESP; a store with error SHALL not modify storage.
REQ-022 A load without error SHALL capture RAM[addr[31:2]] into resp_rdata on the edge that enters RESP.
REQ-023 resp_rdata SHALL be 0 for stores and for errors.
REQ-024 In RESP, SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then go to IDLE on that edge.
REQ-025 Backpressure: resp_ready may stay low indefinitely; no new request is accepted until the response completes.
REQ-026 Throughput SHALL be at most one request per WAIT_CYCLES+2 cycles; req_ready re-asserts the cycle after the response handshake.
REQ-027 Changes of req_* outside a handshake SHALL be ignored.
REQ-028 Outside RESP, resp_valid, resp_err and resp_rdata SHALL be 0.

Reset
REQ-029 reset SHALL force IDLE, clear the counter, and set req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-030 reset during BUSY or RESP SHALL abort the transaction; a pending store SHALL not be written.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 The state enum (IDLE/BUSY/RESP) and the word-size/address-offset constants SHALL reside in a shared package, dmem_pkg.
REQ-033 Storage SHALL be one sub-module, word_ram: DEPTH x 32, synchronous write, combinational read.

Verification
REQ-034 WAIT_CYCLES=2, store 7 to 0x64 -> resp_valid 3 cycles after acceptance, resp_err=0; then load 0x64 -> resp_rdata=0x00000007.
REQ-035 Store 0xDEADBEEF to 0x62 (misaligned) -> resp_err=1; a load of 0x60 returns its prior value unchanged.
REQ-036 Load 0x100 (word 64, DEPTH=64) -> resp_err=1, resp_rdata=0.
REQ-037 Hold resp_ready=0 for 5 cycles after a load response -> resp_valid and data stay stable, req_ready=0; req_ready returns 1 the cycle after resp_ready=1.
REQ-038 WAIT_CYCLES=0 -> resp_valid on the cycle after acceptance; back-to-back store 0x2A to 0x00 then load 0x00 returns 0x2A.
REQ-039 Assert reset in BUSY during store 0x55 to 0x08 -> outputs reach reset values, and a later load of 0x08 returns its old value.
